// File: rtl/cdb_arbiter_buffered_pkg.sv
// Shared types for the buffered common-data-bus arbiter.
package cdb_arbiter_buffered_pkg;

  localparam int CDB_TAG_W  = 5;
  localparam int CDB_DATA_W = 32;

  // Result broadcast on the CDB: producing ROB tag plus the computed value.
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] value;
  } cdb_t;

  typedef enum logic {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } prio_mode_e;

  // Position of the offset-th unit in a scan that starts at 'start' and wraps.
  function automatic int scan_index(input int start, input int offset, input int n);
    return (start + offset) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_buffered_if.sv
// Execution-unit and CDB signal bundle between the units and the arbiter.
interface cdb_arbiter_buffered_if #(
  parameter int NUM_EXEC_UNITS = 4,
  parameter int NUM_CDB_PORTS  = 2
);
  import cdb_arbiter_buffered_pkg::*;

  logic [NUM_EXEC_UNITS-1:0] exec_valid;
  cdb_t                      exec_data [NUM_EXEC_UNITS];
  logic [NUM_EXEC_UNITS-1:0] exec_ready;
  logic [NUM_CDB_PORTS-1:0]  cdb_valid;
  cdb_t                      cdb_out [NUM_CDB_PORTS];

  // Execution units / CDB consumers side.
  modport master (
    output exec_valid, exec_data,
    input  exec_ready, cdb_valid, cdb_out
  );

  // Arbiter side.
  modport slave (
    input  exec_valid, exec_data,
    output exec_ready, cdb_valid, cdb_out
  );

endinterface

// File: rtl/cdb_arbiter_buffered_fifo.sv
// Per-unit holding FIFO; head is visible combinationally so it can be
// granted the cycle after it was written.
module cdb_fifo
  import cdb_arbiter_buffered_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  cdb_t                         push_data,
  input  logic                         pop,
  output cdb_t                         head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign w_do_push = push && (r_count != CNT_W'(DEPTH)) && !flush;
  assign w_do_pop  = pop && (r_count != '0) && !flush;

  assign head  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign count = r_count;

  // Payload storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter_buffered.sv
// N-way CDB arbiter: buffers each unit's results and grants up to
// NUM_CDB_PORTS heads per cycle, starved units first.
module cdb_arbiter_buffered
  import cdb_arbiter_buffered_pkg::*;
#(
  parameter int         NUM_CDB_PORTS  = 2,
  parameter int         NUM_EXEC_UNITS = 4,
  parameter int         BUF_DEPTH      = 2,
  parameter int         STARVE_LIMIT   = 4,
  parameter prio_mode_e PRIO_MODE      = PRIO_FIXED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  cdb_arbiter_buffered_if.slave bus
);
  localparam int PTR_W = (NUM_EXEC_UNITS > 1) ? $clog2(NUM_EXEC_UNITS) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  logic [PTR_W-1:0]          r_rr_ptr;
  logic [PTR_W-1:0]          w_rr_next;
  logic [PTR_W-1:0]          w_rr_last;
  logic                      w_rr_hit;
  logic [AGE_W-1:0]          r_age [NUM_EXEC_UNITS];
  cdb_t                      w_head [NUM_EXEC_UNITS];
  logic [CNT_W-1:0]          w_count [NUM_EXEC_UNITS];
  logic [NUM_EXEC_UNITS-1:0] w_empty;
  logic [NUM_EXEC_UNITS-1:0] w_ready;
  logic [NUM_EXEC_UNITS-1:0] w_push;
  logic [NUM_EXEC_UNITS-1:0] w_grant;
  logic [NUM_CDB_PORTS-1:0]  w_cdb_valid;
  cdb_t                      w_cdb_out [NUM_CDB_PORTS];

  for (genvar gi = 0; gi < NUM_EXEC_UNITS; gi++) begin : g_unit
    // Ready looks only at the registered count, so a full FIFO never
    // accepts even when it is popping in the same cycle.
    assign w_ready[gi] = (w_count[gi] < CNT_FULL) && !flush && rst_n;
    assign w_push[gi]  = bus.exec_valid[gi] && w_ready[gi];

    cdb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (w_push[gi]),
      .push_data (bus.exec_data[gi]),
      .pop       (w_grant[gi]),
      .head      (w_head[gi]),
      .empty     (w_empty[gi]),
      .count     (w_count[gi])
    );
  end

  // Grant selection: urgent units first in index order, then fill remaining
  // ports in scan order; each grant takes the next free CDB port.
  always_comb begin
    int n_granted;
    int pos;
    w_grant     = '0;
    w_rr_hit    = 1'b0;
    w_rr_last   = '0;
    w_cdb_valid = '0;
    for (int p = 0; p < NUM_CDB_PORTS; p++) w_cdb_out[p] = '0;
    n_granted = 0;
    pos       = 0;
    if (!flush) begin
      for (int i = 0; i < NUM_EXEC_UNITS; i++) begin
        if (!w_empty[i] && (r_age[i] == AGE_MAX) && (n_granted < NUM_CDB_PORTS)) begin
          w_grant[i] = 1'b1;
          for (int p = 0; p < NUM_CDB_PORTS; p++) begin
            if (p == n_granted) begin
              w_cdb_valid[p] = 1'b1;
              w_cdb_out[p]   = w_head[i];
            end
          end
          n_granted++;
        end
      end
      for (int k = 0; k < NUM_EXEC_UNITS; k++) begin
        pos = (PRIO_MODE == PRIO_RR) ? scan_index(int'(r_rr_ptr), k, NUM_EXEC_UNITS) : k;
        for (int i = 0; i < NUM_EXEC_UNITS; i++) begin
          if ((i == pos) && !w_empty[i] && !w_grant[i] && (n_granted < NUM_CDB_PORTS)) begin
            w_grant[i] = 1'b1;
            w_rr_hit   = 1'b1;
            w_rr_last  = PTR_W'(i);
            for (int p = 0; p < NUM_CDB_PORTS; p++) begin
              if (p == n_granted) begin
                w_cdb_valid[p] = 1'b1;
                w_cdb_out[p]   = w_head[i];
              end
            end
            n_granted++;
          end
        end
      end
    end
  end

  assign w_rr_next = (int'(w_rr_last) == NUM_EXEC_UNITS - 1) ? '0 : w_rr_last + 1'b1;

  // Round-robin pointer moves past the last unit granted by the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (flush) begin
      r_rr_ptr <= '0;
    end else if ((PRIO_MODE == PRIO_RR) && w_rr_hit) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  // Starvation ages: count denied cycles while holding data, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_EXEC_UNITS; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_EXEC_UNITS; i++) begin
        if (flush || w_empty[i] || w_grant[i]) begin
          r_age[i] <= '0;
        end else if (r_age[i] != AGE_MAX) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

  assign bus.exec_ready = w_ready;
  assign bus.cdb_valid  = w_cdb_valid;
  assign bus.cdb_out    = w_cdb_out;

endmodule

// File: tb/tb_cdb_arbiter_buffered.sv
// Bench: a round-robin 2-port and a fixed-priority 1-port arbiter driven by
// the same stimulus, each compared against a queue-based reference model.
module tb_cdb_arbiter_buffered;
  import cdb_arbiter_buffered_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk;
  logic rst_n;
  logic flush;
  logic [N-1:0] ev;
  cdb_t ed [N];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  cdb_arbiter_buffered_if #(.NUM_EXEC_UNITS(N), .NUM_CDB_PORTS(2)) if_rr ();
  cdb_arbiter_buffered_if #(.NUM_EXEC_UNITS(N), .NUM_CDB_PORTS(1)) if_fx ();

  assign if_rr.exec_valid = ev;
  assign if_rr.exec_data  = ed;
  assign if_fx.exec_valid = ev;
  assign if_fx.exec_data  = ed;

  cdb_arbiter_buffered #(
    .NUM_CDB_PORTS(2), .NUM_EXEC_UNITS(N), .BUF_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT), .PRIO_MODE(PRIO_RR)
  ) dut_rr (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_rr));

  cdb_arbiter_buffered #(
    .NUM_CDB_PORTS(1), .NUM_EXEC_UNITS(N), .BUF_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT), .PRIO_MODE(PRIO_FIXED)
  ) dut_fx (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_fx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs gathered per DUT (index 0 = round-robin, 1 = fixed).
  logic [N-1:0] obs_ready [2];
  logic [1:0]   obs_valid [2];
  cdb_t         obs_out   [2][2];
  always_comb begin
    obs_ready[0]    = if_rr.exec_ready;
    obs_ready[1]    = if_fx.exec_ready;
    obs_valid[0]    = if_rr.cdb_valid;
    obs_valid[1]    = {1'b0, if_fx.cdb_valid};
    obs_out[0][0]   = if_rr.cdb_out[0];
    obs_out[0][1]   = if_rr.cdb_out[1];
    obs_out[1][0]   = if_fx.cdb_out[0];
    obs_out[1][1]   = '0;
  end

  // Reference model: a queue per unit, an age per unit, a scan start.
  cdb_t         mq   [2][N][$];
  int           mage [2][N];
  int           mrr  [2];
  logic [N-1:0] m_ready [2];
  int           m_ngr [2];
  int           m_gu  [2][2];
  int           m_last2 [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        mq[d][i].delete();
        mage[d][i] = 0;
      end
      mrr[d] = 0;
    end
  endtask

  // Who gets the bus this cycle: starved units by index, then scan order.
  task automatic model_eval(input int d);
    bit taken [N];
    int np;
    int u;
    np = (d == 0) ? 2 : 1;
    m_ngr[d]   = 0;
    m_last2[d] = -1;
    for (int i = 0; i < N; i++) begin
      taken[i] = 1'b0;
      m_ready[d][i] = rst_n && !flush && (mq[d][i].size() < DEPTH);
    end
    if (rst_n && !flush) begin
      for (int i = 0; i < N; i++) begin
        if (m_ngr[d] < np && mq[d][i].size() > 0 && mage[d][i] == LIMIT) begin
          m_gu[d][m_ngr[d]] = i;
          m_ngr[d]++;
          taken[i] = 1'b1;
        end
      end
      for (int k = 0; k < N; k++) begin
        u = (d == 0) ? (mrr[d] + k) % N : k;
        if (m_ngr[d] < np && mq[d][u].size() > 0 && !taken[u]) begin
          m_gu[d][m_ngr[d]] = u;
          m_ngr[d]++;
          taken[u] = 1'b1;
          m_last2[d] = u;
        end
      end
    end
  endtask

  // State change at the clock edge, from the values evaluated before it.
  task automatic model_commit(input int d);
    bit granted;
    if (!rst_n) return;
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        mq[d][i].delete();
        mage[d][i] = 0;
      end
      mrr[d] = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      granted = 1'b0;
      for (int p = 0; p < m_ngr[d]; p++) if (m_gu[d][p] == i) granted = 1'b1;
      if (mq[d][i].size() == 0 || granted) mage[d][i] = 0;
      else if (mage[d][i] < LIMIT) mage[d][i]++;
      if (granted) void'(mq[d][i].pop_front());
      if (ev[i] && m_ready[d][i]) mq[d][i].push_back(ed[i]);
    end
    if (m_last2[d] >= 0) mrr[d] = (m_last2[d] + 1) % N;
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int np;
      np = (d == 0) ? 2 : 1;
      model_eval(d);
      chk($sformatf("cyc%0d dut%0d exec_ready", cyc, d), 64'(obs_ready[d]), 64'(m_ready[d]));
      for (int p = 0; p < np; p++) begin
        logic vexp;
        cdb_t oexp;
        vexp = (p < m_ngr[d]);
        oexp = vexp ? mq[d][m_gu[d][p]][0] : '0;
        chk($sformatf("cyc%0d dut%0d cdb_valid[%0d]", cyc, d, p), 64'(obs_valid[d][p]), 64'(vexp));
        chk($sformatf("cyc%0d dut%0d cdb_out[%0d]", cyc, d, p), 64'(obs_out[d][p]), 64'(oexp));
      end
    end
  endtask

  function automatic cdb_t rand_data();
    cdb_t r;
    r.tag   = 5'($urandom);
    r.value = $urandom;
    return r;
  endfunction

  // One cycle: entered at posedge+1, drives, checks mid-cycle, commits.
  task automatic run_cycle_d(input logic fl, input logic [N-1:0] v, input cdb_t dat [N]);
    flush = fl;
    ev    = v;
    ed    = dat;
    #4;
    check_all();
    @(posedge clk);
    model_commit(0);
    model_commit(1);
    cyc++;
    $display("cycle %0d: flush=%0b valid=%b rr_grants=%0d fx_grants=%0d",
             cyc, fl, v, m_ngr[0], m_ngr[1]);
    #1;
  endtask

  task automatic run_cycle(input logic fl, input logic [N-1:0] v);
    cdb_t dat [N];
    for (int i = 0; i < N; i++) dat[i] = rand_data();
    run_cycle_d(fl, v, dat);
  endtask

  initial begin
    cdb_t dv [N];
    cdb_t exp_a;
    cdb_t cap;

    rst_n = 1'b0;
    flush = 1'b0;
    ev    = '0;
    for (int i = 0; i < N; i++) ed[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready rr", 64'(obs_ready[0]), 64'(0));
    chk("reset valid rr", 64'(obs_valid[0]), 64'(0));
    rst_n = 1'b1;
    run_cycle(1'b0, '0);
    chk("post-reset ready rr", 64'(obs_ready[0]), 64'(4'hF));
    chk("post-reset ready fx", 64'(obs_ready[1]), 64'(4'hF));

    // Single push on unit 2, broadcast next cycle on port 0 only.
    run_cycle(1'b1, '0);
    for (int i = 0; i < N; i++) dv[i] = rand_data();
    exp_a.tag   = 5'd2;
    exp_a.value = 32'hA;
    dv[2] = exp_a;
    run_cycle_d(1'b0, 4'b0100, dv);
    chk("single push valid rr", 64'(obs_valid[0]), 64'(2'b01));
    chk("single push out rr", 64'(obs_out[0][0]), 64'(exp_a));
    run_cycle(1'b0, '0);
    // rr_ptr is now 3: unit 3 must precede unit 0 on the RR arbiter.
    for (int i = 0; i < N; i++) dv[i] = rand_data();
    run_cycle_d(1'b0, 4'b1001, dv);
    chk("rr order port0", 64'(obs_out[0][0]), 64'(dv[3]));
    chk("rr order port1", 64'(obs_out[0][1]), 64'(dv[0]));
    chk("fixed order port0", 64'(obs_out[1][0]), 64'(dv[0]));
    repeat (4) run_cycle(1'b0, '0);

    // RR fairness with every unit requesting.
    run_cycle(1'b1, '0);
    repeat (8) run_cycle(1'b0, 4'hF);

    // Starvation: unit 3 wins the single fixed port in cycle 5.
    run_cycle(1'b1, '0);
    for (int c = 1; c <= 7; c++) begin
      run_cycle(1'b0, 4'b1001);
      if (c == 1) cap = mq[1][3][0];
      if (c == 5) chk("starve grant unit3", 64'(obs_out[1][0]), 64'(cap));
    end

    // Backpressure on unit 1 until its urgent grant.
    run_cycle(1'b1, '0);
    for (int c = 1; c <= 6; c++) begin
      run_cycle(1'b0, 4'b0011);
      if (c >= 2) chk($sformatf("backpressure ready1 c%0d", c), 64'(obs_ready[1][1]), 64'(c == 6));
    end

    // Flush with buffered entries and a new entry presented on unit 2.
    run_cycle(1'b1, '0);
    repeat (2) run_cycle(1'b0, 4'b0011);
    run_cycle(1'b1, 4'b0100);
    run_cycle(1'b0, '0);
    run_cycle(1'b0, '0);

    // Asynchronous reset mid-traffic.
    repeat (2) run_cycle(1'b0, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset valid rr", 64'(obs_valid[0]), 64'(0));
    chk("async reset valid fx", 64'(obs_valid[1]), 64'(0));
    chk("async reset ready rr", 64'(obs_ready[0]), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    repeat (2) run_cycle(1'b0, 4'hF);
    rst_n = 1'b1;
    run_cycle(1'b0, '0);
    run_cycle(1'b0, '0);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      run_cycle(($urandom_range(0, 19) == 0), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
